// File: rtl/sap_pkg.sv
// Shared constants for the SAP control path: mode encodings and the
// default select width used by the decoders.
package sap_pkg;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_RING   = 1'b1;

  localparam int SEL_W_DEFAULT = 4;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational one-hot decoder with enable. Reusable wherever a binary
// index has to become a single select line (T-states, ROM address decode).
module onehot_decoder #(
  parameter  int SEL_W = 4,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_out
);

  // Drive exactly one line high when enabled, nothing otherwise.
  always_comb begin
    o_out = '0;
    if (i_en) begin
      o_out[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_ring_decoder.sv
// Registered one-hot decoder with a built-in ring sequencer. DECODE mode
// registers an external select; RING mode steps its own index and wraps at
// a programmable terminal state, pulsing wrap on the cycle it returns to 0.
module onehot_ring_decoder
  import sap_pkg::*;
#(
  parameter  int SEL_W = SEL_W_DEFAULT,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             o_en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic             adv,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] out,
  output logic             wrap
);

  logic [SEL_W-1:0] r_idx;
  logic             r_wrap;
  logic [SEL_W-1:0] w_idxNext;
  logic             w_wrapNext;

  // Next-index mux: DECODE follows sel; RING gives load priority over adv.
  // The terminal compare uses >= so an index loaded past last still wraps,
  // and the wrap to zero is explicit rather than relying on overflow.
  always_comb begin
    w_idxNext  = r_idx;
    w_wrapNext = 1'b0;
    if (mode == MODE_DECODE) begin
      w_idxNext = sel;
    end else if (load) begin
      w_idxNext = sel;
    end else if (adv) begin
      if (r_idx >= last) begin
        w_idxNext  = '0;
        w_wrapNext = 1'b1;
      end else begin
        w_idxNext = r_idx + 1'b1;
      end
    end
  end

  // State register; reset overrides every other control input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_idxNext;
      r_wrap <= w_wrapNext;
    end
  end

  assign idx  = r_idx;
  assign wrap = r_wrap;

  onehot_decoder #(
    .SEL_W (SEL_W)
  ) u_decoder (
    .i_sel (r_idx),
    .i_en  (o_en),
    .o_out (out)
  );

endmodule
